// File: rtl/hps_pll_sup_pkg.sv
// HPS memory PLL supervisor: shared types and defaults.
// State encodings are visible on the state_o debug port.
package hps_pll_sup_pkg;

    typedef enum logic [2:0] {
        ST_RESET_PLL = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABILIZE = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } state_e;

    localparam int DEF_RST_PULSE_CYCLES    = 16;
    localparam int DEF_LOCK_TIMEOUT_CYCLES = 50000;
    localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
    localparam int DEF_MAX_RETRIES         = 3;
    localparam int DEF_CNT_W               = 16;
    localparam int LOSS_CNT_W              = 8;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for level signals crossing into clk_i.
// Both stages reset to 0.
module sync_2ff #(
    parameter int W = 1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    // Capture the async input, then re-register to settle metastability
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/hps_pll_supervisor.sv
// HPS memory PLL supervisor: drives PLL rst, qualifies lock,
// releases downstream reset, retries on timeout, sticky fail.
module hps_pll_supervisor
    import hps_pll_sup_pkg::*;
#(
    parameter int RST_PULSE_CYCLES    = DEF_RST_PULSE_CYCLES,
    parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
    parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
    parameter int MAX_RETRIES         = DEF_MAX_RETRIES,
    parameter int CNT_W               = DEF_CNT_W
) (
    input  logic                  refclk,
    input  logic                  rst_n,
    input  logic                  pll_locked,
    input  logic                  force_relock,
    output logic                  pll_rst,
    output logic                  sys_rst_n,
    output logic                  fail,
    output logic [LOSS_CNT_W-1:0] lock_loss_count,
    output logic [2:0]            state_o
);

    localparam int RTY_W = $clog2(MAX_RETRIES + 1);

    localparam logic [CNT_W-1:0] PULSE_LAST  = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [RTY_W-1:0] RTY_LIMIT   = RTY_W'(MAX_RETRIES);

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [RTY_W-1:0]      retry_q, retry_d;
    logic [RTY_W-1:0]      retry_inc;
    logic                  pll_rst_q, pll_rst_d;
    logic                  sys_rst_n_q, sys_rst_n_d;
    logic                  fail_q, fail_d;
    logic [LOSS_CNT_W-1:0] loss_q, loss_d;
    logic                  locked_s;

    sync_2ff #(
        .W (1)
    ) u_lock_sync (
        .clk_i  (refclk),
        .rst_ni (rst_n),
        .d_i    (pll_locked),
        .q_o    (locked_s)
    );

    assign retry_inc = retry_q + RTY_W'(1);

    // Next-state and registered-output decode
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        retry_d     = retry_q;
        pll_rst_d   = pll_rst_q;
        sys_rst_n_d = sys_rst_n_q;
        fail_d      = fail_q;
        loss_d      = loss_q;

        if (force_relock) begin
            state_d     = ST_RESET_PLL;
            cnt_d       = '0;
            retry_d     = '0;
            fail_d      = 1'b0;
            pll_rst_d   = 1'b1;
            sys_rst_n_d = 1'b0;
        end else begin
            case (state_q)
                ST_RESET_PLL: begin
                    pll_rst_d   = 1'b1;
                    sys_rst_n_d = 1'b0;
                    if (cnt_q == PULSE_LAST) begin
                        state_d   = ST_WAIT_LOCK;
                        cnt_d     = '0;
                        pll_rst_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_WAIT_LOCK: begin
                    if (locked_s) begin
                        state_d = ST_STABILIZE;
                        cnt_d   = '0;
                    end else if (cnt_q == TMO_LAST) begin
                        cnt_d     = '0;
                        retry_d   = retry_inc;
                        pll_rst_d = 1'b1;
                        if (retry_inc == RTY_LIMIT) begin
                            state_d = ST_FAIL;
                            fail_d  = 1'b1;
                        end else begin
                            state_d = ST_RESET_PLL;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_STABILIZE: begin
                    if (!locked_s) begin
                        state_d = ST_WAIT_LOCK;
                        cnt_d   = '0;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_d     = ST_RUN;
                        cnt_d       = '0;
                        retry_d     = '0;
                        sys_rst_n_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    if (!locked_s) begin
                        state_d     = ST_RESET_PLL;
                        cnt_d       = '0;
                        pll_rst_d   = 1'b1;
                        sys_rst_n_d = 1'b0;
                        if (loss_q != '1) begin
                            loss_d = loss_q + LOSS_CNT_W'(1);
                        end
                    end
                end
                ST_FAIL: begin
                    pll_rst_d   = 1'b1;
                    sys_rst_n_d = 1'b0;
                    fail_d      = 1'b1;
                end
                default: begin
                    state_d     = ST_RESET_PLL;
                    cnt_d       = '0;
                    pll_rst_d   = 1'b1;
                    sys_rst_n_d = 1'b0;
                end
            endcase
        end
    end

    // State, counters and outputs all update on the same edge
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RESET_PLL;
            cnt_q       <= '0;
            retry_q     <= '0;
            pll_rst_q   <= 1'b1;
            sys_rst_n_q <= 1'b0;
            fail_q      <= 1'b0;
            loss_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            pll_rst_q   <= pll_rst_d;
            sys_rst_n_q <= sys_rst_n_d;
            fail_q      <= fail_d;
            loss_q      <= loss_d;
        end
    end

    assign pll_rst         = pll_rst_q;
    assign sys_rst_n       = sys_rst_n_q;
    assign fail            = fail_q;
    assign lock_loss_count = loss_q;
    assign state_o         = state_q;

endmodule
